ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes EX-stage operands RS_E/RT_E and a decoded md_op. Runs multi-cycle mult/multu/div/divu and holds the HI/LO architectural registers.
- Exposes busy to the hazard unit, which stalls IF/ID and bubbles ID/EX while a new MD instruction in D would collide.

Parameters:
- MULT_CYCLES, 5, cycles busy is held high for mult/multu.
- DIV_CYCLES, 10, cycles busy is held high for div/divu.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  md_op is valid this cycle (EX holds an MD instruction).
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs  input  32  first operand (forwarded RS_E).
- rt  input  32  second operand (forwarded RT_E).
- busy  output  1  operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, internal counter=0, latched operands/op cleared.
- Reset asserted mid-operation aborts the operation. The result is discarded and all outputs take reset values on the next edge.
- Two states: IDLE, BUSY.
- Accept condition: start=1 and busy=0 at edge t.
- mult/multu/div/divu accepted at edge t:
  - Latch rs, rt, op; counter <= N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 during cycles t+1 .. t+N.
  - Counter decrements each edge. At the edge where counter==0 in BUSY: write hi/lo, busy <= 0, return to IDLE.
  - New hi/lo are visible in the same cycle busy first reads 0. Old hi/lo stay stable throughout BUSY.
- mthi/mtlo accepted at edge t: hi<=rs (or lo<=rs) at that edge. No busy; other register untouched.
- start=1 while busy=1 is ignored, with no effect on state. The hazard unit guarantees this never happens architecturally; the bench checks it anyway.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=upper 32, lo=lower 32.
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero, remainder takes sign of dividend; lo=quotient, hi=remainder.
  - divu: unsigned; lo=quotient, hi=remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): full DIV_CYCLES busy, hi/lo unchanged at completion.
- Result computed from latched operands only. Changes on rs/rt after acceptance have no effect.
- md_op 0 or 7 with start=1: no state change.
- Back-to-back: a new start may be accepted in the cycle busy first reads 0, i.e. the edge right after completion. No dead cycle is required.
- The MEM/WB path reads hi/lo combinationally for mfhi/mflo. The hazard unit stalls mfhi/mflo in D while busy=1 or (start=1 and md_op in 1..4).

Test Plan:
- Reset, then mult with rs=0xFFFFFFFF, rt=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles; hi/lo hold prior values while busy.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with rs=7, rt=2 -> lo=3, hi=1.
- mthi rs=0x12345678, next cycle mtlo rs=0x9ABCDEF0 -> hi/lo updated at each edge, busy stays 0. Then divu by rt=0 -> busy 10 cycles, hi/lo unchanged.
- During a div, pulse start with mult and with mtlo, with rs changing every cycle -> both ignored; div result matches the originally latched operands. mult accepted immediately when busy drops -> busy rises next cycle.
- Start div, assert reset at busy cycle 4 -> next cycle busy=0, hi=0, lo=0. No late write-back occurs in the following 10 cycles.

Source files
------------

// File: rtl/ex_mdu.sv
// ============================================================================
// Module  : ex_mdu
// Brief   : EX-stage multi-cycle multiply/divide unit holding HI/LO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic [31:0]        a_q, b_q;
   logic [31:0]        hi_q, lo_q;
   logic [31:0]        hi_d, lo_d;

   logic               is_mult, sext, a_neg, b_neg;
   logic [63:0]        a_ext, b_ext, prod;
   logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag;

   // Datapath works only from latched operands; signed divide goes through
   // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
   always_comb begin
      is_mult = (op_q == OP_MULT) || (op_q == OP_MULTU);
      sext    = (op_q == OP_MULT);
      a_ext   = {{32{sext & a_q[31]}}, a_q};
      b_ext   = {{32{sext & b_q[31]}}, b_q};
      prod    = a_ext * b_ext;

      a_neg   = (op_q == OP_DIV) && a_q[31];
      b_neg   = (op_q == OP_DIV) && b_q[31];
      a_mag   = a_neg ? (32'd0 - a_q) : a_q;
      b_mag   = b_neg ? (32'd0 - b_q) : b_q;
      b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag   = a_mag / b_safe;
      r_mag   = a_mag % b_safe;

      hi_d = hi_q;
      lo_d = lo_q;
      if (is_mult) begin
         hi_d = prod[63:32];
         lo_d = prod[31:0];
      end else if (b_q != 32'd0) begin
         lo_d = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
         hi_d = a_neg ? (32'd0 - r_mag) : r_mag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            case (md_op)
               OP_MULT, OP_MULTU: begin
                  op_q    <= md_op;
                  a_q     <= rs;
                  b_q     <= rt;
                  cnt_q   <= CNT_W'(MULT_CYCLES - 1);
                  state_q <= S_BUSY;
               end
               OP_DIV, OP_DIVU: begin
                  op_q    <= md_op;
                  a_q     <= rs;
                  b_q     <= rt;
                  cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                  state_q <= S_BUSY;
               end
               OP_MTHI: hi_q <= rs;
               OP_MTLO: lo_q <= rs;
               default: ;
            endcase
         end
      end else begin
         if (cnt_q == '0) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            state_q <= S_IDLE;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign busy = (state_q == S_BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mdu.sv
// ============================================================================
// Module  : tb_ex_mdu
// Brief   : Vector-table and directed-sequence bench for ex_mdu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs = 32'd0;
   logic [31:0] rt = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cyc;
   } vec_t;

   vec_t        vecs [14];
   logic [31:0] cur_hi, cur_lo;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      int n;
      start = 1'b1;
      md_op = vecs[i].op;
      rs    = vecs[i].a;
      rt    = vecs[i].b;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         rs = $urandom;
         rt = $urandom;
         check($sformatf("v%0d hold_hi", i), hi, cur_hi);
         check($sformatf("v%0d hold_lo", i), lo, cur_lo);
         n++;
         tick();
      end
      check($sformatf("v%0d busy_cycles", i), 32'(n), 32'(vecs[i].cyc));
      check($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
      cur_hi = vecs[i].exp_hi;
      cur_lo = vecs[i].exp_lo;
   endtask

   initial begin
      int n;
      vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
      vecs[4]  = '{3'd5, 32'h12345678, 32'h0000AAAA, 32'h12345678, 32'h00000003, 0};
      vecs[5]  = '{3'd6, 32'h9ABCDEF0, 32'h0000BBBB, 32'h12345678, 32'h9ABCDEF0, 0};
      vecs[6]  = '{3'd4, 32'h00000055, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 10};
      vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[11] = '{3'd0, 32'h11111111, 32'h22222222, 32'hFFFFFFFE, 32'h00000001, 0};
      vecs[12] = '{3'd7, 32'h33333333, 32'h44444444, 32'hFFFFFFFE, 32'h00000001, 0};
      vecs[13] = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};

      tick();
      tick();
      reset = 1'b0;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      cur_hi = 32'd0;
      cur_lo = 32'd0;

      for (int i = 0; i < 14; i++) run_vec(i);

      // Foreign starts during a divide are ignored; operands keep changing.
      start = 1'b1;
      md_op = 3'd3;
      rs    = 32'd100;
      rt    = 32'd7;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         check("ign hold_hi", hi, cur_hi);
         check("ign hold_lo", lo, cur_lo);
         rs    = $urandom;
         rt    = $urandom;
         start = (n == 2) || (n == 4);
         md_op = (n == 4) ? 3'd6 : 3'd1;
         tick();
      end
      check("ign busy_cycles", 32'(n), 32'd10);
      check("ign lo", lo, 32'd14);
      check("ign hi", hi, 32'd2);

      // Back-to-back: mult accepted on the first non-busy cycle.
      start = 1'b1;
      md_op = 3'd1;
      rs    = 32'd3;
      rt    = 32'hFFFFFFFE;
      tick();
      start = 1'b0;
      check("b2b busy_rise", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      check("b2b busy_cycles", 32'(n), 32'd5);
      check("b2b hi", hi, 32'hFFFFFFFF);
      check("b2b lo", lo, 32'hFFFFFFFA);

      // Reset during busy cycle 4 aborts the divide.
      start = 1'b1;
      md_op = 3'd3;
      rs    = 32'd100;
      rt    = 32'd7;
      tick();
      start = 1'b0;
      check("rst busy_c1", {31'd0, busy}, 32'd1);
      tick();
      tick();
      tick();
      check("rst busy_c4", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst abort busy", {31'd0, busy}, 32'd0);
      check("rst abort hi", hi, 32'd0);
      check("rst abort lo", lo, 32'd0);
      for (int k = 0; k < 12; k++) begin
         tick();
         check("rst late busy", {31'd0, busy}, 32'd0);
         check("rst late hi", hi, 32'd0);
         check("rst late lo", lo, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
